// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Feeds a gated prediction and its registered copy to the IF PC controller.
module btb_predictor #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            i_branch_taken,
  input  logic            i_trap_taken,
  input  logic            i_any_holdoff,
  input  logic            i_spanning_in_progress,
  input  logic            i_invalidate,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  output logic            o_predicted_taken,
  output logic [XLEN-1:0] o_predicted_target,
  output logic            o_prediction_used,
  output logic            o_sel_prediction_r,
  output logic [XLEN-1:0] o_predicted_target_r,
  output logic            o_prediction_holdoff
);

  localparam int IDX_BITS = $clog2(BTB_DEPTH);
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;

  logic                valid_q [BTB_DEPTH];
  logic [1:0]          ctr_q   [BTB_DEPTH];
  logic [TAG_BITS-1:0] tag_q   [BTB_DEPTH];
  logic [XLEN-1:0]     tgt_q   [BTB_DEPTH];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [TAG_BITS-1:0] up_tag;
  logic                rd_hit;
  logic                up_hit;
  logic                up_en;
  logic                redirect;
  logic                sel_r;
  logic [XLEN-1:0]     tgt_r;
  logic                unused_ok;

  assign rd_idx = i_pc[IDX_BITS+1:2];
  assign rd_tag = i_pc[XLEN-1:IDX_BITS+2];
  assign up_idx = i_upd_pc[IDX_BITS+1:2];
  assign up_tag = i_upd_pc[XLEN-1:IDX_BITS+2];

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en  = i_upd_valid && !i_upd_pc[1];

  assign redirect = i_flush || i_branch_taken || i_trap_taken;

  assign o_predicted_taken  = rd_hit && ctr_q[rd_idx][1] && !i_pc[1];
  assign o_predicted_target = rd_hit ? tgt_q[rd_idx] : '0;

  assign o_prediction_used = o_predicted_taken
                          && !i_stall
                          && !redirect
                          && !i_any_holdoff
                          && !i_spanning_in_progress
                          && !sel_r;

  assign o_sel_prediction_r   = sel_r;
  assign o_predicted_target_r = tgt_r;
  assign o_prediction_holdoff = sel_r;

  assign unused_ok = ^{i_pc[0], i_upd_pc[0]};

  // Valid bits and counters: train on resolved branches, flash-clear on invalidate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else begin
      if (up_en) begin
        unique case (1'b1)
          up_hit && i_upd_taken: begin
            if (ctr_q[up_idx] != 2'b11)
              ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
          end
          up_hit && !i_upd_taken: begin
            if (ctr_q[up_idx] != 2'b00)
              ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
          end
          !up_hit && i_upd_taken: begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= 2'b10;
          end
          default: ;
        endcase
      end
      if (i_invalidate) begin
        for (int i = 0; i < BTB_DEPTH; i++)
          valid_q[i] <= 1'b0;
      end
    end
  end

  // Tag and target storage; only meaningful while the entry is valid.
  always_ff @(posedge i_clk) begin
    if (up_en && i_upd_taken) begin
      tgt_q[up_idx] <= i_upd_target;
      tag_q[up_idx] <= up_tag;
    end
  end

  // Registered prediction copy for the PC controller, one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_r <= 1'b0;
      tgt_r <= '0;
    end else if (redirect) begin
      sel_r <= 1'b0;
    end else if (!i_stall) begin
      sel_r <= o_prediction_used;
      if (o_prediction_used)
        tgt_r <= o_predicted_target;
    end
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer plus 2-bit saturating-counter predictor; sits directly upstream of the IF-stage PC controller.
- Looks up the current fetch PC every cycle and supplies a combinational prediction, a gated "prediction used" strobe and the registered copies the PC controller needs to advance the instruction PC one cycle later.
- Trained by resolved branches and jumps from EX.

Parameters:
XLEN, 32, address/data width
BTB_DEPTH, 16, number of entries; power of two, >= 2; IDX_BITS = log2(BTB_DEPTH)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_pc  in  XLEN  current fetch PC (PC controller o_pc)
i_stall  in  1  pipeline stall
i_flush  in  1  pipeline flush
i_branch_taken  in  1  EX redirect this cycle
i_trap_taken  in  1  trap or MRET redirect this cycle
i_any_holdoff  in  1  stale-instruction holdoff from PC controller
i_spanning_in_progress  in  1  32-bit instruction spanning two fetch words
i_invalidate  in  1  clear all entries (FENCE.I)
i_upd_valid  in  1  EX resolved a branch/jump this cycle
i_upd_pc  in  XLEN  PC of resolved instruction
i_upd_taken  in  1  resolved outcome
i_upd_target  in  XLEN  resolved target
o_predicted_taken  out  1  raw BTB hit and predict-taken
o_predicted_target  out  XLEN  raw predicted target
o_prediction_used  out  1  gated prediction, steers next PC this cycle
o_sel_prediction_r  out  1  o_prediction_used delayed one cycle
o_predicted_target_r  out  XLEN  o_predicted_target captured with o_prediction_used
o_prediction_holdoff  out  1  asserted the cycle after a used prediction

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX_BITS+2], target[XLEN-1:0], ctr[1:0]. Index = pc[IDX_BITS+1:2]. Storage is flops; lookup is combinational.
- Lookup:
  - hit = valid && tag match.
  - o_predicted_taken = hit && ctr[1] && !i_pc[1]. Halfword-aligned PCs never predict.
  - o_predicted_target = entry target when hit, else 0.
- Gating: o_prediction_used = o_predicted_taken && !i_stall && !i_flush && !i_any_holdoff && !i_spanning_in_progress && !i_branch_taken && !i_trap_taken && !o_sel_prediction_r. No back-to-back predictions.
- Registered outputs, at each clock edge:
  - If i_flush, i_branch_taken or i_trap_taken: o_sel_prediction_r is cleared to 0.
  - Else if i_stall: o_sel_prediction_r and o_predicted_target_r hold.
  - Else: o_sel_prediction_r <= o_prediction_used, and o_predicted_target_r <= o_predicted_target whenever o_prediction_used=1.
  - o_prediction_holdoff = o_sel_prediction_r (combinational alias).
- Update, at the clock edge when i_upd_valid=1:
  - Hit, taken: ctr saturating +1 (max 3); target <= i_upd_target.
  - Hit, not taken: ctr saturating -1 (min 0). Entry stays valid at ctr=0.
  - Miss, taken: allocate. valid=1, tag and target written, ctr=2 (weakly taken), overwriting any existing entry.
  - Miss, not taken: no change.
  - Updates with i_upd_pc[1]=1 are ignored.
- Update is not blocked by i_stall or i_flush, since EX has already resolved the branch.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents; the new contents are visible from the next cycle.
- i_invalidate: all valid bits clear at the next edge and override a same-cycle update. Registered outputs are unaffected.
- Reset (async, any time): all valid=0, ctr=0, o_sel_prediction_r=0, o_predicted_target_r=0.
  - Combinational outputs are therefore 0 during reset: o_predicted_taken, o_predicted_target, o_prediction_used, o_prediction_holdoff.
  - Targets and tags need not be reset.
- Latency: prediction is combinational, zero cycles. Training becomes visible one cycle after the update edge.

Test Plan:
- Reset, then i_pc=0x100 with no updates -> o_predicted_taken=0, o_prediction_used=0, o_sel_prediction_r=0.
- Update pc=0x100 taken target=0x200, then i_pc=0x100 -> taken=1, target=0x200, used=1. Next cycle o_sel_prediction_r=1, o_predicted_target_r=0x200, o_prediction_holdoff=1. Used is blocked in that cycle even if i_pc=0x100 again.
- Entry at ctr=2, two not-taken updates -> ctr=0 and prediction drops after the first. Three taken updates -> ctr saturates at 3. One not-taken then still predicts taken.
- Predicting hit with i_pc=0x102, or with i_stall / i_any_holdoff / i_spanning_in_progress / i_branch_taken asserted -> o_predicted_taken follows the rules above, o_prediction_used=0. With i_stall, registered outputs hold their values.
- Alias check with BTB_DEPTH=16: pc 0x100 trained, then taken update at 0x140 (same index, new tag) -> 0x100 misses, 0x140 hits. Same-cycle lookup of 0x140 during that update still misses.
- Trained entry, assert i_invalidate together with an update -> all lookups miss next cycle. Assert i_rst_n=0 mid-stream, between edges -> o_sel_prediction_r drops immediately and the table is empty after release.
